sspim_sck_shift: RTL and testbench

//  Serial back end of the single SPI master, directly downstream of sspim_ctl.
//  - Divides clk into alternating one-cycle shift/sample strobes.
//  - Drives the SPI clock (sck) from sck_active and cfg_cpol.
//  - Loads byte_out into an 8-bit transmit shifter on load_byte; sdo is MSB first.
//  - Assembles sdi into byte_in.

---
 rtl/sspim_sck_shift.sv | 113 +++++++++++
 tb/tb_sspim_sck_shift.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sspim_sck_shift.sv
// sspim_sck_shift
//   Serial back end of the single SPI master, sitting directly behind
//   sspim_ctl. It divides clk into alternating one-cycle sample/shift
//   strobes, drives the SPI clock pad from those strobes, shifts the
//   transmit byte out MSB first and assembles the received byte.
//
// Ports
//   clk             system clock, all logic on its rising edge
//   reset_n         asynchronous active-low reset
//   sck_en          divider enable; low holds the divider idle
//   cfg_sck_period  sck half-period in clk cycles, minus 1
//   cfg_cpol        sck idle level
//   sck_active      ctl allows sck toggling and data shifting
//   load_byte       one-cycle pulse: capture byte_out into the shifter
//   byte_out        next transmit byte
//   byte_in         received byte, MSB first
//   shift           one-cycle strobe on the launch edge
//   sample          one-cycle strobe on the capture edge
//   sck             SPI clock pad
//   sdo             SPI serial data out (shifter MSB)
//   sdi             SPI serial data in, already synchronised

module sspim_sck_shift #(
    parameter int DIV_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sck_en,
    input  logic [DIV_W-1:0] cfg_sck_period,
    input  logic             cfg_cpol,
    input  logic             sck_active,
    input  logic             load_byte,
    input  logic [7:0]       byte_out,
    output logic [7:0]       byte_in,
    output logic             shift,
    output logic             sample,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi
);

    logic [DIV_W-1:0] div_cnt;
    logic             phase;
    logic             div_tc;
    logic [7:0]       tx_sr;

    // The compare is against the live configuration, so a new period takes
    // effect on the next compare. If the counter is already past it, the
    // counter simply runs on and wraps through zero.
    assign div_tc = (div_cnt == cfg_sck_period);

    // Divider: phase 0 -> 1 produces sample, phase 1 -> 0 produces shift,
    // so the first strobe after enable is always a sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            sample  <= 1'b0;
            shift   <= 1'b0;
        end else if (!sck_en) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            sample  <= 1'b0;
            shift   <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            phase   <= ~phase;
            sample  <= ~phase;
            shift   <= phase;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            sample  <= 1'b0;
            shift   <= 1'b0;
        end
    end

    // sck follows the strobes with one clk of latency; the strobes keep
    // running while sck_active is low so ctl can time CS setup/hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck <= 1'b0;
        end else if (!sck_active) begin
            sck <= cfg_cpol;
        end else if (sample) begin
            sck <= ~cfg_cpol;
        end else if (shift) begin
            sck <= cfg_cpol;
        end
    end

    // A fresh load wins over a coincident shift so the new MSB is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sr <= 8'h00;
        end else if (load_byte) begin
            tx_sr <= byte_out;
        end else if (shift && sck_active) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
    end

    assign sdo = tx_sr[7];

    // byte_in is never cleared between bytes; eight samples replace it fully.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_in <= 8'h00;
        end else if (sample && sck_active) begin
            byte_in <= {byte_in[6:0], sdi};
        end
    end

endmodule

// File: tb/tb_sspim_sck_shift.sv
module tb_sspim_sck_shift;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sck_en;
    logic [5:0] cfg_sck_period;
    logic       cfg_cpol;
    logic       sck_active;
    logic       load_byte;
    logic [7:0] byte_out;
    logic [7:0] byte_in;
    logic       shift;
    logic       sample;
    logic       sck;
    logic       sdo;
    logic       sdi;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] byte_q[$];

    sspim_sck_shift #(.DIV_W(6)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sck_en         (sck_en),
        .cfg_sck_period (cfg_sck_period),
        .cfg_cpol       (cfg_cpol),
        .sck_active     (sck_active),
        .load_byte      (load_byte),
        .byte_out       (byte_out),
        .byte_in        (byte_in),
        .shift          (shift),
        .sample         (sample),
        .sck            (sck),
        .sdo            (sdo),
        .sdi            (sdi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [7:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_empty: observed %h expected queued entry", obs);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    // One full byte: 8 sample/shift pairs with sck_active held throughout.
    // Expected strobe/sck/sdo values come from the closed-form timing:
    // sample at t = (2k+1)(P+1), shift at t = (2k+2)(P+1), sck leaving idle
    // one clk after each sample and returning one clk after each shift.
    task automatic run_xfer(input int p, input logic cpol, input logic [7:0] tx,
                            input logic [7:0] rx, input bit loop);
        int half;
        int k;
        logic es, esh, ek;
        half           = p + 1;
        cfg_sck_period = 6'(p);
        cfg_cpol       = cpol;
        sck_en         = 1'b0;
        sck_active     = 1'b0;
        byte_out       = tx;
        load_byte      = 1'b1;
        tick();
        load_byte = 1'b0;
        tick();
        push("sck_idle_pre", {7'b0, cpol});
        pop_cmp({7'b0, sck});
        byte_q.push_back(loop ? tx : rx);
        if (loop) sdi = sdo;
        sck_en     = 1'b1;
        sck_active = 1'b1;
        for (int t = 1; t <= 16 * half; t++) begin
            es  = (t % (2 * half) == half);
            esh = (t % (2 * half) == 0);
            ek  = (((t - 1) % (2 * half)) >= half) ? ~cpol : cpol;
            push("sample", {7'b0, es});
            push("shift", {7'b0, esh});
            push("sck", {7'b0, ek});
            tick();
            pop_cmp({7'b0, sample});
            pop_cmp({7'b0, shift});
            pop_cmp({7'b0, sck});
            if (es) begin
                k = (t / half - 1) / 2;
                push("sdo_at_sample", {7'b0, tx[7-k]});
                pop_cmp({7'b0, sdo});
                if (!loop) sdi = rx[7-k];
            end
            if (loop) sdi = sdo;
        end
        sck_active = 1'b0;
        sck_en     = 1'b0;
        tick();
        chk("sck_idle_post", {7'b0, sck}, {7'b0, cpol});
        if (byte_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL byte_q_empty: observed %h expected queued byte", byte_in);
        end else begin
            chk("byte_in", byte_in, byte_q.pop_front());
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        sck_en         = 1'b0;
        cfg_sck_period = 6'd0;
        cfg_cpol       = 1'b0;
        sck_active     = 1'b0;
        load_byte      = 1'b0;
        byte_out       = 8'h00;
        sdi            = 1'b0;
        #12;
        chk("rst_sck", {7'b0, sck}, 8'h00);
        chk("rst_sdo", {7'b0, sdo}, 8'h00);
        chk("rst_byte_in", byte_in, 8'h00);
        chk("rst_strobes", {6'b0, sample, shift}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rel_sck_cpol0", {7'b0, sck}, 8'h00);

        // Period 3, cpol 0: strobe cadence plus A5 out MSB first, 5A in.
        run_xfer(3, 1'b0, 8'hA5, 8'h5A, 1'b0);
        // Period 2, cpol 1: 3C assembled from sdi, sck idles high.
        run_xfer(2, 1'b1, 8'h00, 8'h3C, 1'b0);
        // Period 0: strobes every cycle, FF loopback.
        run_xfer(0, 1'b0, 8'hFF, 8'h00, 1'b1);

        // load_byte coincident with shift, then sck_en dropped mid-byte.
        cfg_sck_period = 6'd1;
        cfg_cpol       = 1'b0;
        byte_out       = 8'hFF;
        load_byte      = 1'b1;
        tick();
        load_byte  = 1'b0;
        sck_en     = 1'b1;
        sck_active = 1'b1;
        tick();
        tick();
        chk("t5_sample_t2", {7'b0, sample}, 8'h01);
        tick();
        tick();
        chk("t5_shift_t4", {7'b0, shift}, 8'h01);
        byte_out  = 8'h81;
        load_byte = 1'b1;
        tick();
        load_byte = 1'b0;
        chk("t5_load_wins_sdo", {7'b0, sdo}, 8'h01);
        tick();
        chk("t5_sample_t6", {7'b0, sample}, 8'h01);
        chk("t5_sdo_t6", {7'b0, sdo}, 8'h01);
        sck_en = 1'b0;
        tick();
        chk("t5_stop_strobes", {6'b0, sample, shift}, 8'h00);
        sck_en = 1'b1;
        tick();
        chk("t5_restart_quiet", {6'b0, sample, shift}, 8'h00);
        tick();
        chk("t5_restart_sample", {6'b0, sample, shift}, 8'h02);
        sck_en     = 1'b0;
        sck_active = 1'b0;
        tick();

        // Reset mid-byte with cpol 1 while sck is low.
        cfg_sck_period = 6'd1;
        cfg_cpol       = 1'b1;
        byte_out       = 8'hC3;
        load_byte      = 1'b1;
        tick();
        load_byte  = 1'b0;
        sdi        = 1'b1;
        sck_en     = 1'b1;
        sck_active = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_pre_sck_low", {7'b0, sck}, 8'h00);
        chk("t6_pre_sdo", {7'b0, sdo}, 8'h01);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_sck", {7'b0, sck}, 8'h00);
        chk("t6_rst_sdo", {7'b0, sdo}, 8'h00);
        chk("t6_rst_byte_in", byte_in, 8'h00);
        chk("t6_rst_strobes", {6'b0, sample, shift}, 8'h00);
        sck_en     = 1'b0;
        sck_active = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("t6_rel_sck_before_edge", {7'b0, sck}, 8'h00);
        tick();
        chk("t6_rel_sck_cpol1", {7'b0, sck}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
